// File: rtl/alu_hilo_seq.sv
// alu_hilo_seq: HI/LO mult/div sequencer (iterative, 1 bit/cycle), owns hi/lo.
// Ports: clock, reset(async low), flush, req_* handshake, rsp_*, busy, div_zero, hi, lo.
// Optional divider datapath: define ALU_HILO_SEQ_DIV_EN.
module alu_hilo_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic               rdy;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  ph;
  logic [DATA_W-1:0]  pl;
  logic [DATA_W-1:0]  mc;
  logic               neg_q;
`ifdef ALU_HILO_SEQ_DIV_EN
  logic               neg_r;
  logic               is_div;
  logic [DATA_W:0]    trial;
`endif

  logic               accept;
  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [DATA_W-1:0]  mag1;
  logic [DATA_W-1:0]  mag2;
  logic               op_mul;
  logic               op_div;
  logic               op_mth;
  logic               op_mtl;
  logic               op_mfh;
  logic               op_mfl;

  logic [DATA_W:0]    add_s;
  logic [2*DATA_W-1:0] run_nxt;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_f;
  logic [DATA_W-1:0]  fix_hi;
  logic [DATA_W-1:0]  fix_lo;

  // rdy holds ready low until the first edge after reset release
  assign req_ready = rdy && (state == IDLE);
  assign busy      = (state != IDLE);
  // flush on an accept edge drops the request
  assign accept    = req_valid && req_ready && !flush;

  assign op_mul = (req_op[2:1] == 2'd0);
  assign op_div = (req_op[2:1] == 2'd1);
  assign op_mth = (req_op == 3'd4);
  assign op_mtl = (req_op == 3'd5);
  assign op_mfh = (req_op == 3'd6);
  assign op_mfl = (req_op == 3'd7);

  // even opcodes among mult/div are the signed forms
  assign sgn   = ~req_op[0];
  assign a_neg = sgn & req_data1[DATA_W-1];
  assign b_neg = sgn & req_data2[DATA_W-1];
  assign mag1  = a_neg ? (~req_data1 + 1'b1) : req_data1;
  assign mag2  = b_neg ? (~req_data2 + 1'b1) : req_data2;

  always_comb begin
    add_s   = {1'b0, ph} + {1'b0, mc};
    // shift-add: {ph,pl} is the partial product, pl drains the multiplier
    run_nxt = pl[0] ? {add_s, pl[DATA_W-1:1]}
                    : {1'b0, ph, pl[DATA_W-1:1]};
    prod    = {ph, pl};
    prod_f  = neg_q ? (~prod + 1'b1) : prod;
    fix_hi  = prod_f[2*DATA_W-1:DATA_W];
    fix_lo  = prod_f[DATA_W-1:0];
`ifdef ALU_HILO_SEQ_DIV_EN
    // restoring divide: ph is the remainder, pl shifts dividend out / quotient in
    trial = {ph, pl[DATA_W-1]} - {1'b0, mc};
    if (is_div) begin
      run_nxt = trial[DATA_W] ? {ph[DATA_W-2:0], pl, 1'b0}
                              : {trial[DATA_W-1:0], pl[DATA_W-2:0], 1'b1};
      fix_lo  = neg_q ? (~pl + 1'b1) : pl;
      fix_hi  = neg_r ? (~ph + 1'b1) : ph;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      cnt       <= '0;
      ph        <= '0;
      pl        <= '0;
      mc        <= '0;
      neg_q     <= 1'b0;
`ifdef ALU_HILO_SEQ_DIV_EN
      neg_r     <= 1'b0;
      is_div    <= 1'b0;
`endif
      hi        <= '0;
      lo        <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      rdy       <= 1'b1;
      rsp_valid <= 1'b0;
      div_zero  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              op_mul: begin
                state  <= RUN;
                cnt    <= CNT_W'(DATA_W);
                ph     <= '0;
                pl     <= mag2;
                mc     <= mag1;
                neg_q  <= a_neg ^ b_neg;
`ifdef ALU_HILO_SEQ_DIV_EN
                is_div <= 1'b0;
`endif
              end
              op_div: begin
`ifdef ALU_HILO_SEQ_DIV_EN
                if (req_data2 == '0) begin
                  div_zero <= 1'b1;
                end else begin
                  state  <= RUN;
                  cnt    <= CNT_W'(DATA_W);
                  ph     <= '0;
                  pl     <= mag1;
                  mc     <= mag2;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  is_div <= 1'b1;
                end
`else
                // no divider: flag as unsupported
                div_zero <= 1'b1;
`endif
              end
              op_mth: hi <= req_data1;
              op_mtl: lo <= req_data1;
              op_mfh: begin
                rsp_valid <= 1'b1;
                rsp_data  <= hi;
              end
              op_mfl: begin
                rsp_valid <= 1'b1;
                rsp_data  <= lo;
              end
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            {ph, pl} <= run_nxt;
            cnt      <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
